// File: rtl/poly_div2_seq_pkg.sv
// Shared constants and state encoding for the in-place polynomial halving sequencer.
package poly_div2_seq_pkg;

    localparam int COEF_N  = 256;
    localparam int COEF_AW = 8;
    localparam int COEF_DW = 24;
    localparam int HALF_KW = 5;

    localparam logic [COEF_DW-1:0] Q_DILITHIUM = 24'd8380417;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_HALF = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

endpackage

// File: rtl/poly_div2_seq_if.sv
// Shared coefficient RAM port: one read and one write channel behind a single grant.
interface poly_div2_seq_if #(
    parameter int AW = 8,
    parameter int DW = 24
);
    logic          mem_gnt;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    modport master (
        input  mem_gnt, mem_rdata,
        output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output mem_gnt, mem_rdata,
        input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/poly_div2_seq_div2.sv
// Purpose: combinational halving modulo q (x * 2^-1 mod q for odd q).
// Latency: zero cycles, pure combinational.
// Backpressure: none.
module poly_div2 #(
    parameter int DW = 24
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] y
);
    logic [DW-1:0] q_half_up;

    // (q+1)/2 formed as (q>>1)+1 so an all-ones q cannot overflow.
    assign q_half_up = (q >> 1) + DW'(1);
    assign y         = (x[0] & q[0]) ? (x >> 1) + q_half_up : (x >> 1);
endmodule

// File: rtl/poly_div2_seq.sv
// Purpose: halve every RAM coefficient k times modulo q, written back in place.
// Latency: N*(3+k)+1 cycles from accepted start to done with grant held high.
// Backpressure: RD and WR hold address/data stable while mem_gnt is low.
module poly_div2_seq
    import poly_div2_seq_pkg::*;
#(
    parameter int N  = COEF_N,
    parameter int AW = COEF_AW,
    parameter int DW = COEF_DW,
    parameter int KW = HALF_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] q,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    poly_div2_seq_if.master mem
);
    logic [2:0]    state;
    logic [DW-1:0] q_r;
    logic [KW-1:0] k_r;
    logic [AW-1:0] idx;
    logic [DW-1:0] acc;
    logic [KW-1:0] hcnt;
    logic [DW-1:0] half;

    poly_div2 #(.DW(DW)) u_div2 (
        .x (acc),
        .q (q_r),
        .y (half)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            q_r   <= '0;
            k_r   <= '0;
            idx   <= '0;
            acc   <= '0;
            hcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_r   <= q;
                        k_r   <= k;
                        idx   <= '0;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (mem.mem_gnt) state <= ST_CAP;
                end
                ST_CAP: begin
                    acc   <= mem.mem_rdata;
                    hcnt  <= k_r;
                    state <= (k_r != '0) ? ST_HALF : ST_WR;
                end
                ST_HALF: begin
                    acc  <= half;
                    hcnt <= hcnt - KW'(1);
                    if (hcnt == KW'(1)) state <= ST_WR;
                end
                ST_WR: begin
                    if (mem.mem_gnt) begin
                        if (idx == AW'(N - 1)) begin
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= ST_RD;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state alone so a reset zeroes them in the same cycle.
    assign mem.mem_re    = (state == ST_RD);
    assign mem.mem_raddr = (state == ST_RD) ? idx : '0;
    assign mem.mem_we    = (state == ST_WR);
    assign mem.mem_waddr = (state == ST_WR) ? idx : '0;
    assign mem.mem_wdata = (state == ST_WR) ? acc : '0;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FIN);
endmodule

// File: tb/tb_poly_div2_seq.sv
// Directed bench for poly_div2_seq with a behavioural coefficient RAM.
module tb_poly_div2_seq;
    import poly_div2_seq_pkg::*;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int DW = 24;
    localparam int KW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] q_in;
    logic [KW-1:0] k_in;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    poly_div2_seq_if #(.AW(AW), .DW(DW)) mif ();

    poly_div2_seq #(.N(N), .AW(AW), .DW(DW), .KW(KW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q_in),
        .k     (k_in),
        .busy  (busy),
        .done  (done),
        .mem   (mif.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] img [N];
    logic [DW-1:0] expv [N];
    logic          load_req = 1'b0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;

    // RAM model: read data valid only the cycle after a granted read, noise otherwise.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (mif.mem_gnt && mif.mem_we) begin
            mem[mif.mem_waddr] <= mif.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mif.mem_gnt && mif.mem_re) begin
            mif.mem_rdata <= mem[mif.mem_raddr];
            rd_cnt <= rd_cnt + 1;
        end else begin
            mif.mem_rdata <= 24'($urandom);
        end
        if (mif.mem_re && mif.mem_we) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [DW-1:0] ref_half(input logic [DW-1:0] x, input logic [DW-1:0] qq);
        logic [DW:0] s;
        s = (x[0] && qq[0]) ? ({1'b0, x} + {1'b0, qq}) : {1'b0, x};
        return s[DW:1];
    endfunction

    task automatic load_img();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // mode 0 plain, 1 grant stalls, 2 second start mid-run, 3 leave at HALF of coefficient 10
    task automatic run_op(input logic [KW-1:0] kk, input int mode,
                          output int cyc, output int busy_low, output int unstable);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit rd_st, wr_st;
        rd_st = 0; wr_st = 0; busy_low = 0; unstable = 0;
        q_in = Q_DILITHIUM; k_in = kk; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            if (!busy) busy_low++;
            if (mode == 3 && cyc == 43) return;
            if (mode == 2 && cyc == 100) begin k_in = 5'd3; q_in = 24'd17; start = 1'b1; end
            if (mode == 2 && cyc == 101) start = 1'b0;
            if (mode == 1 && !rd_st && mif.mem_re && mif.mem_raddr == 8'd5) begin
                a = mif.mem_raddr;
                mif.mem_gnt = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1; cyc++;
                    if (!mif.mem_re || mif.mem_raddr !== a) unstable++;
                end
                mif.mem_gnt = 1'b1;
                rd_st = 1;
            end
            if (mode == 1 && !wr_st && mif.mem_we && mif.mem_waddr == 8'd7) begin
                a = mif.mem_waddr;
                d = mif.mem_wdata;
                mif.mem_gnt = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1; cyc++;
                    if (!mif.mem_we || mif.mem_waddr !== a || mif.mem_wdata !== d) unstable++;
                end
                mif.mem_gnt = 1'b1;
                wr_st = 1;
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, mif.mem_re, mif.mem_we} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, mif.mem_re, mif.mem_we});
        end
        checks++;
        if ({mif.mem_raddr, mif.mem_waddr, mif.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_bus: got raddr=%0d waddr=%0d wdata=%0d required 0",
                               mif.mem_raddr, mif.mem_waddr, mif.mem_wdata);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    endtask

    task automatic test_k1();
        int cyc, bl, un, bad;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom_range(0, 8380416));
        img[0] = 24'd1; img[1] = 24'd6;
        load_img();
        run_op(5'd1, 0, cyc, bl, un);
        checks++;
        if (cyc !== 1025) begin errors++; $display("FAIL k1_latency: got %0d required 1025", cyc); end
        #2;
        checks++;
        if (mem[0] !== 24'd4190209) begin errors++; $display("FAIL k1_coeff0: got %0d required 4190209", mem[0]); end
        checks++;
        if (mem[1] !== 24'd3) begin errors++; $display("FAIL k1_coeff1: got %0d required 3", mem[1]); end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_half(img[i], Q_DILITHIUM)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL k1_all: %0d coefficients wrong, required 0", bad); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL k1_done_pulse: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_k2();
        int cyc, bl, un;
        for (int i = 0; i < N; i++) img[i] = 24'(i);
        img[0] = 24'd1;
        load_img();
        run_op(5'd2, 0, cyc, bl, un);
        checks++;
        if (cyc !== 1281) begin errors++; $display("FAIL k2_latency: got %0d required 1281", cyc); end
        @(posedge clk); #1;
        checks++;
        if (mem[0] !== 24'd6285313) begin errors++; $display("FAIL k2_coeff0: got %0d required 6285313", mem[0]); end
        checks++;
        if (mem[8] !== 24'd2) begin errors++; $display("FAIL k2_coeff8: got %0d required 2", mem[8]); end
    endtask

    task automatic test_k0();
        int cyc, bl, un, bad, rd0, wr0;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        load_img();
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(5'd0, 0, cyc, bl, un);
        checks++;
        if (cyc !== 769) begin errors++; $display("FAIL k0_latency: got %0d required 769", cyc); end
        checks++;
        if (bl !== 0) begin errors++; $display("FAIL k0_busy: low for %0d cycles required 0", bl); end
        @(posedge clk); #1;
        checks++;
        if (rd_cnt - rd0 !== 256 || wr_cnt - wr0 !== 256) begin
            errors++; $display("FAIL k0_traffic: reads=%0d writes=%0d required 256 256", rd_cnt - rd0, wr_cnt - wr0);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== img[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL k0_unchanged: %0d coefficients changed, required 0", bad); end
    endtask

    task automatic test_stall();
        int cyc, bl, un, bad;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom_range(0, 8380416));
        load_img();
        run_op(5'd1, 1, cyc, bl, un);
        checks++;
        if (cyc !== 1030) begin errors++; $display("FAIL stall_latency: got %0d required 1030", cyc); end
        checks++;
        if (un !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles required 0", un); end
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_half(img[i], Q_DILITHIUM)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_data: %0d coefficients wrong, required 0", bad); end
    endtask

    task automatic test_restart_ignored();
        int cyc, bl, un, bad, d0;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom_range(0, 8380416));
        load_img();
        d0 = done_cnt;
        run_op(5'd1, 2, cyc, bl, un);
        checks++;
        if (cyc !== 1025) begin errors++; $display("FAIL restart_latency: got %0d required 1025", cyc); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL restart_done_count: got %0d required 1", done_cnt - d0); end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_half(img[i], Q_DILITHIUM)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL restart_data: %0d coefficients wrong, required 0", bad); end
    endtask

    task automatic test_rst_mid();
        int cyc, bl, un, bad, wr0;
        for (int i = 0; i < N; i++) img[i] = 24'(i * 1000 + 20);
        load_img();
        wr0 = wr_cnt;
        run_op(5'd1, 3, cyc, bl, un);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mif.mem_re, mif.mem_we} !== 4'b0 || mif.mem_wdata !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: ctrl=%b wdata=%0d required 0000 0",
                               {busy, done, mif.mem_re, mif.mem_we}, mif.mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (mem[10] !== 24'd10020) begin errors++; $display("FAIL rst_mid_addr10: got %0d required 10020", mem[10]); end
        checks++;
        if (mem[9] !== 24'd4510 || wr_cnt - wr0 !== 10) begin
            errors++; $display("FAIL rst_mid_prior: coeff9=%0d writes=%0d required 4510 10", mem[9], wr_cnt - wr0);
        end
        for (int i = 0; i < N; i++)
            expv[i] = (i < 10) ? ref_half(ref_half(img[i], Q_DILITHIUM), Q_DILITHIUM) : ref_half(img[i], Q_DILITHIUM);
        run_op(5'd1, 0, cyc, bl, un);
        checks++;
        if (cyc !== 1025) begin errors++; $display("FAIL rst_rerun_latency: got %0d required 1025", cyc); end
        @(posedge clk); #1;
        checks++;
        if (mem[0] !== 24'd5 || mem[10] !== 24'd5010) begin
            errors++; $display("FAIL rst_rerun_coeffs: c0=%0d c10=%0d required 5 5010", mem[0], mem[10]);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== expv[i]) bad++;
        checks++;
        if (bad != 0 || both_cnt != 0) begin
            errors++; $display("FAIL rst_rerun_all: wrong=%0d re_we_overlap=%0d required 0 0", bad, both_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        q_in = '0;
        k_in = '0;
        mif.mem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_k1();
        test_k2();
        test_k0();
        test_stall();
        test_restart_ignored();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_div2_seq.md
Name: poly_div2_seq

Overview:
- Sequencer that walks a polynomial stored in coefficient RAM and halves every coefficient modulo q, k times (multiplies by 2^-k mod q), writing each result back in place.
- Owns one instance of the team's combinational modular-halving unit and time-shares it across all coefficients.
- Sits between the NTT/poly-arith controller (start/done) and the shared coefficient RAM port (request/grant).
- Used for scaling after inverse NTT and for Montgomery-factor removal.

Parameters:
- N, 256, coefficients per polynomial.
- AW, 8, RAM address width; N == 2^AW.
- DW, 24, coefficient and modulus width.
- KW, 5, width of the halving count k (0..31).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- q  in  DW  modulus; sampled on accepted start.
- k  in  KW  number of halvings; sampled on accepted start.
- mem_gnt  in  1  RAM port grant; a read or write is accepted only in a cycle with gnt=1.
- mem_re  out  1  read request.
- mem_raddr  out  AW  read address.
- mem_rdata  in  DW  read data, valid exactly 1 cycle after an accepted read.
- mem_we  out  1  write request.
- mem_waddr  out  AW  write address.
- mem_wdata  out  DW  write data.
- busy  out  1  high from the accepted start until the DONE state exits.
- done  out  1  one-cycle pulse when the last write is accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, idx=0, halving counter=0, accumulator=0.
- Registers:
  - q_r, k_r: latched on accepted start.
  - idx: AW bits, current coefficient.
  - acc: DW bits.
  - hcnt: KW bits, halvings remaining.
- FSM states: IDLE, RD, CAP, HALF, WR, FIN.
  - IDLE: start=1 -> latch q and k, idx=0, go to RD. Otherwise stay.
  - RD: mem_re=1, mem_raddr=idx. If gnt=1, go to CAP; if gnt=0, hold outputs and stay.
  - CAP: acc <= mem_rdata, hcnt <= k_r. Go to HALF if k_r != 0, else to WR.
  - HALF: acc <= div2(acc, q_r), hcnt <= hcnt-1. When hcnt==1, go to WR.
  - WR: mem_we=1, mem_waddr=idx, mem_wdata=acc. If gnt=0, hold and stay. If gnt=1 and idx==N-1, go to FIN. If gnt=1 otherwise, idx <= idx+1 and go to RD.
  - FIN: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- mem_re and mem_we are never asserted together.
- Latency:
  - With gnt held at 1, each coefficient takes 3+k cycles.
  - Start accepted at cycle 0 -> done asserted at cycle N*(3+k)+1.
  - Every gnt=0 cycle in RD or WR adds exactly one cycle.
- Arithmetic: delegated entirely to the halving unit.
  - Odd q, odd x: (x>>1)+(q+1)/2.
  - Otherwise: x>>1.
  - Inputs are not range-checked; coefficients >= q pass through the unit's formula unmodified.
  - The sequencer adds no reduction of its own.
- Boundary conditions:
  - start while busy: ignored; q and k inputs are not re-sampled mid-run.
  - k=0: every coefficient is read and rewritten unchanged (the full memory pass still happens).
  - idx wraps only after FIN; no addresses outside 0..N-1 are ever issued.
  - rst asserted mid-operation: immediate return to IDLE, all outputs 0 in the same cycle. A write not yet granted is dropped; earlier writes are not rolled back.
  - mem_rdata is sampled only in CAP; its value in other cycles is ignored.

Decomposition:
- Shared package holds:
  - coefficient width (24) and Dilithium q constant 8380417;
  - N=256 and AW=8;
  - state encoding enum (IDLE, RD, CAP, HALF, WR, FIN).
- One sub-module: the existing modular-halving unit POLY_DIV2, instantiated once.
  - Inputs: acc and q_r.
  - Output: registered into acc in HALF.
- No other sub-modules; the FSM, counters and port muxing live in poly_div2_seq.

Test Plan:
- q=8380417, k=1, coeff[0]=1, coeff[1]=6, gnt=1 -> coeff[0]=4190209, coeff[1]=3; done at cycle 1025 after start.
- q=8380417, k=2, coeff[0]=1 -> coeff[0]=6285313 (4*6285313 mod q = 1); done at cycle 1281.
- k=0, random RAM contents -> RAM unchanged, 256 reads and 256 writes observed, done at cycle 769, busy high throughout.
- k=1, gnt driven low for 3 cycles during a RD and 2 cycles during a WR -> addresses held stable while stalled, results correct, done delayed by exactly 5 cycles.
- start pulsed again mid-run with a different k -> ignored; original k applied to all 256 coefficients, single done pulse.
- rst asserted during HALF of coefficient 10 -> outputs 0 immediately, no write to address 10; new start with k=1 rewrites from address 0 correctly.
